// File: rtl/decode_pkg.sv
// Shared types and constants for the pipelined instruction decode stage.
package decode_pkg;

    // Instruction class, taken directly from inst[1:0]
    typedef enum logic [1:0] {
        IT_R = 2'b00,
        IT_I = 2'b01,
        IT_S = 2'b10,
        IT_U = 2'b11
    } itype_e;

    // Decode stage control state
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // Major opcodes, inst[6:2]
    localparam logic [4:0] OP_BASE   = 5'b00000;
    localparam logic [4:0] OP_MUL    = 5'b00001;
    localparam logic [4:0] OP_LOGIC  = 5'b00010;
    localparam logic [4:0] OP_DIV    = 5'b00011;
    localparam logic [4:0] OP_CMPX   = 5'b00100;
    localparam logic [4:0] OP_MINMAX = 5'b00111;

    // Function-3 selectors, inst[14:12]
    localparam logic [2:0] F3_0 = 3'd0;
    localparam logic [2:0] F3_1 = 3'd1;
    localparam logic [2:0] F3_2 = 3'd2;
    localparam logic [2:0] F3_3 = 3'd3;
    localparam logic [2:0] F3_4 = 3'd4;
    localparam logic [2:0] F3_5 = 3'd5;
    localparam logic [2:0] F3_6 = 3'd6;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD    = 5'b00000;
    localparam logic [4:0] ALU_SUB    = 5'b00001;
    localparam logic [4:0] ALU_MUL    = 5'b00010;
    localparam logic [4:0] ALU_MULH   = 5'b00011;
    localparam logic [4:0] ALU_MULHSU = 5'b00100;
    localparam logic [4:0] ALU_MULHU  = 5'b00101;
    localparam logic [4:0] ALU_DIV    = 5'b00110;
    localparam logic [4:0] ALU_DIVU   = 5'b00111;
    localparam logic [4:0] ALU_REM    = 5'b01000;
    localparam logic [4:0] ALU_REMU   = 5'b01001;
    localparam logic [4:0] ALU_DIVW   = 5'b01010;
    localparam logic [4:0] ALU_AND    = 5'b01011;
    localparam logic [4:0] ALU_OR     = 5'b01100;
    localparam logic [4:0] ALU_NAND   = 5'b01101;
    localparam logic [4:0] ALU_XOR    = 5'b01110;
    localparam logic [4:0] ALU_NOR    = 5'b01111;
    localparam logic [4:0] ALU_ANDN   = 5'b10000;
    localparam logic [4:0] ALU_XNOR   = 5'b10001;
    localparam logic [4:0] ALU_MIN    = 5'b10010;
    localparam logic [4:0] ALU_MAX    = 5'b10011;
    localparam logic [4:0] ALU_MINU   = 5'b10100;
    localparam logic [4:0] ALU_SLT    = 5'b10101;
    localparam logic [4:0] ALU_SLTU   = 5'b10110;
    localparam logic [4:0] ALU_SEQ    = 5'b10111;
    localparam logic [4:0] ALU_SNE    = 5'b11000;
    localparam logic [4:0] ALU_SLL    = 5'b11010;
    localparam logic [4:0] ALU_SRA    = 5'b11011;
    localparam logic [4:0] ALU_SRL    = 5'b11100;
    localparam logic [4:0] ALU_ROR    = 5'b11101;

    // Width-independent part of a decoded bundle
    typedef struct packed {
        logic [4:0] aluop;
        itype_e     itype;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } dec_t;

    // Register-form lookup: returns {legal, aluop}
    function automatic logic [5:0] rtype_lookup(input logic [4:0] op, input logic [2:0] f3);
        logic [5:0] r;
        r = '0;
        case (op)
            OP_BASE: case (f3)
                F3_0: r = {1'b1, ALU_ADD};
                F3_1: r = {1'b1, ALU_SUB};
                F3_2: r = {1'b1, ALU_SLT};
                F3_3: r = {1'b1, ALU_SLTU};
                F3_4: r = {1'b1, ALU_SLL};
                F3_5: r = {1'b1, ALU_SRL};
                default: r = '0;
            endcase
            OP_CMPX: case (f3)
                F3_2: r = {1'b1, ALU_SEQ};
                F3_3: r = {1'b1, ALU_SNE};
                F3_4: r = {1'b1, ALU_SRA};
                F3_5: r = {1'b1, ALU_ROR};
                default: r = '0;
            endcase
            OP_MUL: case (f3)
                F3_0: r = {1'b1, ALU_MUL};
                F3_1: r = {1'b1, ALU_MULH};
                F3_2: r = {1'b1, ALU_MULHSU};
                F3_3: r = {1'b1, ALU_MULHU};
                F3_4: r = {1'b1, ALU_DIV};
                default: r = '0;
            endcase
            OP_DIV: case (f3)
                F3_1: r = {1'b1, ALU_DIVU};
                F3_2: r = {1'b1, ALU_REM};
                F3_3: r = {1'b1, ALU_REMU};
                F3_4: r = {1'b1, ALU_DIVW};
                default: r = '0;
            endcase
            OP_LOGIC: case (f3)
                F3_0: r = {1'b1, ALU_AND};
                F3_1: r = {1'b1, ALU_OR};
                F3_2: r = {1'b1, ALU_XOR};
                F3_3: r = {1'b1, ALU_ANDN};
                F3_4: r = {1'b1, ALU_NAND};
                F3_5: r = {1'b1, ALU_NOR};
                F3_6: r = {1'b1, ALU_XNOR};
                default: r = '0;
            endcase
            OP_MINMAX: case (f3)
                F3_0: r = {1'b1, ALU_MIN};
                F3_1: r = {1'b1, ALU_MAX};
                F3_3: r = {1'b1, ALU_MINU};
                default: r = '0;
            endcase
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decoder: fields, ALU op, legality and immediate.
module decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    output dec_t            dec,
    output logic [XLEN-1:0] imm
);

    logic [5:0] rlook;
    logic [4:0] op;
    logic [2:0] f3;
    logic       legal;

    // Decode one instruction word into a bundle
    always_comb begin
        dec       = '0;
        imm       = '0;
        legal     = 1'b1;
        op        = inst[6:2];
        f3        = inst[14:12];
        rlook     = rtype_lookup(op, f3);
        dec.itype = itype_e'(inst[1:0]);
        dec.rs1   = inst[19:15];
        dec.rs2   = inst[24:20];
        dec.rd    = inst[11:7];
        dec.aluop = ALU_ADD;
        case (dec.itype)
            IT_R: begin
                legal     = rlook[5];
                dec.aluop = rlook[4:0];
            end
            IT_I: begin
                // Immediate forms reuse the register table, minus OP_CMPX and the
                // OP_BASE entries that have no immediate variant
                legal     = rlook[5] && (op != OP_CMPX) &&
                            ((op != OP_BASE) || (f3 == F3_2) || (f3 == F3_4) || (f3 == F3_5));
                dec.aluop = rlook[4:0];
                imm       = XLEN'($signed(inst[31:20]));
            end
            IT_S: begin
                imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            default: begin
                imm = XLEN'($signed({inst[31:12], 12'h000}));
            end
        endcase
        if (!legal) begin
            dec.aluop = ALU_ADD;
        end
        dec.illegal = !legal;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshakes, 1-entry skid buffer and trap FSM.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_aluop,
    output logic [1:0]      out_itype,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal,
    output logic            trapped
);

    dec_t            in_dec;
    logic [XLEN-1:0] in_imm;

    dec_t            out_q;
    logic [XLEN-1:0] out_imm_q;
    logic [XLEN-1:0] out_pc_q;
    logic            out_valid_q;

    dec_t            skid_q;
    logic [XLEN-1:0] skid_imm_q;
    logic [XLEN-1:0] skid_pc_q;
    logic            skid_full, skid_full_n;

    logic            in_ready_q, in_ready_n;
    logic            accept, out_free;
    state_e          state, state_n;

    decode_comb #(.XLEN(XLEN)) u_comb (
        .inst (in_inst),
        .dec  (in_dec),
        .imm  (in_imm)
    );

    assign accept   = in_valid && in_ready_q && !flush;
    assign out_free = !out_valid_q || out_ready;

    // Next state, next skid occupancy and next in_ready
    always_comb begin
        state_n     = state;
        skid_full_n = out_free ? 1'b0 : (skid_full || accept);
        if (flush) begin
            state_n     = ST_RUN;
            skid_full_n = 1'b0;
        end else if (accept && in_dec.illegal && TRAP_ON_ILLEGAL) begin
            state_n = ST_TRAP;
        end
        in_ready_n = (state_n == ST_RUN) && !skid_full_n;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_n;
        end
    end

    // Output register, skid entry and registered in_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            skid_full   <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            skid_full  <= skid_full_n;
            in_ready_q <= in_ready_n;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (out_free) begin
                // in_ready is low whenever the skid is full, so no accept competes with the drain
                if (skid_full) begin
                    out_q       <= skid_q;
                    out_imm_q   <= skid_imm_q;
                    out_pc_q    <= skid_pc_q;
                    out_valid_q <= 1'b1;
                end else if (accept) begin
                    out_q       <= in_dec;
                    out_imm_q   <= in_imm;
                    out_pc_q    <= in_pc;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= in_dec;
                skid_imm_q <= in_imm;
                skid_pc_q  <= in_pc;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_aluop   = out_q.aluop;
    assign out_itype   = out_q.itype;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign trapped     = (state == ST_TRAP);

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined successor to the combinational ALU-op decoder.
- Registers the decode of one 32-bit instruction per cycle into ALUOp, register indices, sign-extended immediate and instruction type.
- Sits between fetch and the register-read/ALU stage. Uses valid/ready handshakes on both sides with a 1-entry skid buffer.
- Adds two behaviours the old decoder lacked: an explicit illegal-instruction flag, and a trap state that stalls intake until flushed.

Parameters:
- XLEN, 32, datapath width of out_imm, in_pc and out_pc; must be >= 32.
- TRAP_ON_ILLEGAL, 1, 1 = enter TRAP after delivering an illegal instruction; 0 = flag it only and keep running.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all buffered/registered work and return to RUN
- in_valid  in  1  instruction offered by fetch
- in_ready  out  1  decode_stage can accept this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of in_inst
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_aluop  out  5  ALU operation code
- out_itype  out  2  inst[1:0]: 00 R, 01 I, 10 S, 11 U
- out_rs1  out  5  inst[19:15]
- out_rs2  out  5  inst[24:20]
- out_rd  out  5  inst[11:7]
- out_imm  out  XLEN  decoded immediate (0 for R)
- out_pc  out  XLEN  PC carried through
- out_illegal  out  1  bundle is an illegal encoding
- trapped  out  1  state == TRAP

Behaviour:
- Field extraction: opcode = inst[6:2], f3 = inst[14:12].
- R-type ALUOp by (opcode, f3); any combination not listed is illegal:
  - op 00000: f3 000→00000, 001→00001, 010→10101, 011→10110, 100→11010, 101→11100
  - op 00100: f3 010→10111, 011→11000, 100→11011, 101→11101
  - op 00001: f3 000..100 → 00010..00110 in order
  - op 00011: f3 001→00111, 010→01000, 011→01001, 100→01010
  - op 00010: f3 000→01011, 001→01100, 010→01110, 011→10000, 100→01101, 101→01111, 110→10001
  - op 00111: f3 000→10010, 001→10011, 011→10100
- I-type ALUOp:
  - op 00000: only f3 010, 100, 101 are legal, with R-type values.
  - Opcodes 00001, 00011, 00010, 00111: same as R-type.
  - op 00100 and all others: illegal.
- S-type and U-type: ALUOp = 00000 (address/LUI add). All opcodes legal.
- Immediates:
  - I: sign-extend inst[31:20] to XLEN.
  - S: sign-extend {inst[31:25], inst[11:7]}.
  - U: {inst[31:12], 12'b0}, sign-extended to XLEN.
- Illegal bundle: out_aluop = 00000, out_illegal = 1. All other fields decoded normally.
- Latency: an accepted instruction appears on out_* the next cycle (1 cycle).
- Output hold: out_* are stable while out_valid && !out_ready.
- Skid buffer: in_ready is registered. in_ready = (state == RUN) && !skid_full.
  - If the output register is stalled when an instruction is accepted, it goes to the skid entry.
  - The skid entry drains into the output register on the next out_ready.
- Throughput: 1 instruction per cycle when out_ready is held high.
- FSM states RUN and TRAP:
  - RUN → TRAP when an illegal instruction is accepted and TRAP_ON_ILLEGAL = 1.
  - In TRAP, in_ready = 0. Bundles already accepted, including the illegal one, still drain normally.
  - TRAP → RUN only on flush.
- flush:
  - Next cycle: out_valid = 0, skid emptied, state = RUN, in_ready = 1.
  - An in_valid in the same cycle as flush is dropped.
  - flush has priority over out_ready.
- rst: same as flush, and additionally all out_* data fields = 0, out_illegal = 0, trapped = 0, in_ready = 0 in the reset cycle.
- rst asserted mid-stall discards both entries.
- rst has priority over flush.

Decomposition:
- Package decode_pkg holds:
  - itype enum (R, I, S, U)
  - opcode and f3 constants
  - 5-bit ALUOp localparams (ALU_ADD = 00000 … ALU_10111 group named by function)
  - FSM state enum
  - decoded bundle struct
- One sub-module, decode_comb: purely combinational inst → {aluop, illegal, imm, fields}. decode_stage wraps it with the registers, skid buffer and FSM.

Test Plan:
- R add: in_inst with type 00, op 00000, f3 000, rs1=3, rs2=7, rd=1, out_ready=1 → next cycle out_valid=1, aluop=00000, rs1=3, rs2=7, rd=1, imm=0, illegal=0.
- I imm: type 01, op 00010, f3 110, inst[31:20]=0xFFF → aluop=10001, imm=all-ones (XLEN), illegal=0. Repeat with XLEN=64.
- Back-pressure: 3 back-to-back instructions with out_ready=0 for 2 cycles → in_ready drops after 2 accepted; order preserved and no loss on release; throughput 1 per cycle after release.
- Illegal + trap: type 01, op 00100 → out_illegal=1, aluop=00000, trapped=1 the following cycle, in_ready=0 until flush. After flush, RUN with in_ready=1. With TRAP_ON_ILLEGAL=0, trapped stays 0.
- S/U: S with {inst[31:25], inst[11:7]} = 0x800 → imm sign-extended negative. U with inst[31:12] = 0x12345 → imm = 0x12345000, aluop=00000.
- Flush/reset collision: flush and in_valid in the same cycle while stalled → nothing emitted. rst asserted during a stall → all outputs 0 next cycle, in_ready=1 after rst is released.
